regfile_write_arbiter: RTL and testbench

Shares the single register-file write port (writeEn/dest/writeVal, committed on negedge clk) between two requesters. The pipeline writeback stage (WB) has priority. A multi-cycle unit (MC, e.g. mult/div) is buffered in a small FIFO. The block sits between WB/MC and regFile, adds a starvation guard for MC, and flags read-after-write hazards on registers that still have queued MC writes.

---
 rtl/regfile_arb_pkg.sv | 18 +
 rtl/regfile_wr_fifo.sv | 76 +++++++
 rtl/regfile_write_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file write arbiter: address/data widths,
// arbiter state encoding and the queued write entry.
package regfile_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef enum logic [0:0] {
        WB_PRI = 1'b0,
        FORCE  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     val;
    } wr_entry_t;

endpackage

// File: rtl/regfile_wr_fifo.sv
// Small synchronous FIFO of pending multi-cycle-unit writes. Occupancy is kept
// in its own counter and every occupied entry reports a dest match for src1/src2.
module regfile_wr_fifo
    import regfile_arb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wr_entry_t             push_data,
    input  logic                  pop,
    output wr_entry_t             head,
    output logic [CNT_W-1:0]      count,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    output logic [DEPTH-1:0]      match1,
    output logic [DEPTH-1:0]      match2
);

    wr_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok, pop_ok;
    logic [DEPTH-1:0]   occupied;

    assign push_ok = push && (count_q != CNT_W'(DEPTH));
    assign pop_ok  = pop && (count_q != '0);

    // Pointers wrap naturally at the power-of-two depth; the separate count
    // disambiguates full from empty when they coincide.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_comb begin
        // NOTE: every output of this block is assigned on every path, so no latch is inferred.
        occupied = '0;
        match1   = '0;
        match2   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupied[i] = CNT_W'(PTR_W'(i - int'(rd_ptr_q))) < count_q;
            match1[i]   = occupied[i] && (mem_q[i].dest == src1);
            match2[i]   = occupied[i] && (mem_q[i].dest == src2);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; stale contents are masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between WB (priority) and a
// FIFO-buffered multi-cycle unit, with a starvation guard and RAW hazard flags.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter  int DEPTH    = 4,
    parameter  int MAX_WAIT = 8,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0]     wb_val,
    output logic                  wb_ready,
    input  logic                  mc_valid,
    input  logic [REG_ADDR_W-1:0] mc_dest,
    input  logic [DATA_W-1:0]     mc_val,
    output logic                  mc_ready,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_dest,
    output logic [DATA_W-1:0]     rf_wval,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    output logic                  hazard1,
    output logic                  hazard2,
    output logic [CNT_W-1:0]      fifo_count
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    arb_state_e            state_q, state_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_dest_q, rf_dest_d;
    logic [DATA_W-1:0]     rf_wval_q, rf_wval_d;

    logic                  fifo_empty;
    logic                  push_store;
    logic                  grant_wb, grant_mc;
    wr_entry_t             head;
    wr_entry_t             push_data;
    logic [DEPTH-1:0]      match1, match2;

    assign mc_ready   = fifo_count < CNT_W'(DEPTH);
    assign fifo_empty = (fifo_count == '0);
    // A dest-0 push completes its handshake but is dropped here.
    assign push_store = mc_valid && mc_ready && (mc_dest != '0);
    assign push_data  = '{dest: mc_dest, val: mc_val};

    regfile_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_store),
        .push_data (push_data),
        .pop       (grant_mc),
        .head      (head),
        .count     (fifo_count),
        .src1      (src1),
        .src2      (src2),
        .match1    (match1),
        .match2    (match2)
    );

    always_comb begin
        grant_wb   = 1'b0;
        grant_mc   = 1'b0;
        state_d    = WB_PRI;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            WB_PRI: begin
                if (wb_valid && (wb_dest != '0)) begin
                    grant_wb = 1'b1;
                end else if (!fifo_empty) begin
                    grant_mc = 1'b1;
                end
            end
            FORCE:   grant_mc = !fifo_empty;
            default: grant_mc = 1'b0;
        endcase

        // The head has been passed over MAX_WAIT times: lock WB out for one cycle.
        if (grant_mc || fifo_empty) begin
            wait_cnt_d = '0;
        end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            if (wait_cnt_d == WAIT_W'(MAX_WAIT)) begin
                state_d = FORCE;
            end
        end
    end

    always_comb begin
        rf_we_d   = grant_wb || grant_mc;
        rf_dest_d = rf_dest_q;
        rf_wval_d = rf_wval_q;
        if (grant_wb) begin
            rf_dest_d = wb_dest;
            rf_wval_d = wb_val;
        end else if (grant_mc) begin
            rf_dest_d = head.dest;
            rf_wval_d = head.val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= WB_PRI;
            wait_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_dest_q  <= '0;
            rf_wval_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_dest_q  <= rf_dest_d;
            rf_wval_q  <= rf_wval_d;
        end
    end

    assign wb_ready = (state_q == WB_PRI);
    assign rf_we    = rf_we_q;
    assign rf_dest  = rf_dest_q;
    assign rf_wval  = rf_wval_q;
    // The entry already in the rf_* stage is excluded: the negedge write lands before the next read.
    assign hazard1  = (src1 != '0) && (|match1);
    assign hazard2  = (src2 != '0) && (|match2);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a queue-based model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_regfile_write_arbiter;
    import regfile_arb_pkg::*;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  wb_valid, mc_valid;
    logic [REG_ADDR_W-1:0] wb_dest, mc_dest, src1, src2;
    logic [DATA_W-1:0]     wb_val, mc_val;
    logic                  wb_ready, mc_ready, rf_we, hazard1, hazard2;
    logic [REG_ADDR_W-1:0] rf_dest;
    logic [DATA_W-1:0]     rf_wval;
    logic [2:0]            fifo_count;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_val(wb_val), .wb_ready(wb_ready),
        .mc_valid(mc_valid), .mc_dest(mc_dest), .mc_val(mc_val), .mc_ready(mc_ready),
        .rf_we(rf_we), .rf_dest(rf_dest), .rf_wval(rf_wval),
        .src1(src1), .src2(src2), .hazard1(hazard1), .hazard2(hazard2),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    wr_entry_t             mq[$];
    int                    m_wait  = 0;
    bit                    m_force = 1'b0;
    logic                  m_we    = 1'b0;
    logic [REG_ADDR_W-1:0] m_dest  = '0;
    logic [DATA_W-1:0]     m_val   = '0;

    always @(posedge clk or negedge rst) begin
        int n;
        bit accepted;
        bit popped;
        if (!rst) begin
            mq.delete();
            m_wait  = 0;
            m_force = 1'b0;
            m_we    = 1'b0;
            m_dest  = '0;
            m_val   = '0;
        end else begin
            n        = mq.size();
            accepted = mc_valid && (n < DEPTH);
            popped   = 1'b0;
            m_we     = 1'b0;
            if (!m_force && wb_valid && wb_dest != 0) begin
                m_we   = 1'b1;
                m_dest = wb_dest;
                m_val  = wb_val;
            end else if (n > 0) begin
                m_we   = 1'b1;
                m_dest = mq[0].dest;
                m_val  = mq[0].val;
                void'(mq.pop_front());
                popped = 1'b1;
            end
            m_force = 1'b0;
            if (popped || n == 0) begin
                m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == MAX_WAIT) m_force = 1'b1;
            end
            if (accepted && mc_dest != 0) mq.push_back('{dest: mc_dest, val: mc_val});
        end
    end

    function automatic bit exp_hazard(input logic [REG_ADDR_W-1:0] s);
        if (s == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].dest == s) return 1'b1;
        return 1'b0;
    endfunction

    logic [REG_ADDR_W-1:0] wlog[$];
    bit                    log_en = 1'b0;

    always @(negedge clk) begin
        check("rf_we", rf_we, m_we);
        check("rf_dest", rf_dest, m_dest);
        check("rf_wval", rf_wval, m_val);
        check("fifo_count", fifo_count, mq.size());
        check("wb_ready", wb_ready, !m_force);
        check("mc_ready", mc_ready, mq.size() < DEPTH);
        check("hazard1", hazard1, exp_hazard(src1));
        check("hazard2", hazard2, exp_hazard(src2));
        if (log_en && rf_we && rf_dest != 9) wlog.push_back(rf_dest);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid = 0; wb_dest = 0; wb_val = 0;
        mc_valid = 0; mc_dest = 0; mc_val = 0;
        src1 = 0; src2 = 0;
    endtask

    task automatic push_hold(input logic [REG_ADDR_W-1:0] d, input logic [DATA_W-1:0] v);
        mc_valid = 1; mc_dest = d; mc_val = v;
        for (int k = 0; k < 40; k++) begin
            if (mc_ready) begin
                tick();
                mc_valid = 0;
                return;
            end
            tick();
        end
        checks++;
        errors++;
        $display("FAIL push_timeout: dest %0d not accepted within 40 cycles", d);
        mc_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1;
        #1 rst = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1;
        tick();

        // 1: asynchronous reset with two queued writes
        wb_valid = 1; wb_dest = 9; wb_val = 32'h99;
        push_hold(4, 32'h44);
        push_hold(6, 32'h66);
        src1 = 4; src2 = 6;
        #1;
        check("t1_count_pre", fifo_count, 2);
        check("t1_haz1_pre", hazard1, 1);
        check("t1_haz2_pre", hazard2, 1);
        check("t1_we_pre", rf_we, 1);
        #1 rst = 0;
        #1;
        check("t1_we_rst", rf_we, 0);
        check("t1_count_rst", fifo_count, 0);
        check("t1_haz1_rst", hazard1, 0);
        check("t1_haz2_rst", hazard2, 0);
        check("t1_wb_ready_rst", wb_ready, 1);
        check("t1_mc_ready_rst", mc_ready, 1);
        idle();
        @(posedge clk);
        #3 rst = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t1_no_stale", rf_we, 0);
        end

        // 2: WB only
        wb_valid = 1; wb_dest = 5; wb_val = 32'hA5;
        #1 check("t2_wb_ready", wb_ready, 1);
        tick();
        wb_valid = 0;
        #1;
        check("t2_we", rf_we, 1);
        check("t2_dest", rf_dest, 5);
        check("t2_val", rf_wval, 32'hA5);
        check("t2_wb_ready1", wb_ready, 1);
        tick();
        check("t2_we_off", rf_we, 0);
        check("t2_dest_hold", rf_dest, 5);

        // 3: MC with WB idle
        mc_valid = 1; mc_dest = 7; mc_val = 32'h1234; src1 = 7;
        #1;
        check("t3_haz_t", hazard1, 0);
        check("t3_count_t", fifo_count, 0);
        tick();
        mc_valid = 0;
        #1;
        check("t3_count_t1", fifo_count, 1);
        check("t3_haz_t1", hazard1, 1);
        tick();
        check("t3_we_t2", rf_we, 1);
        check("t3_dest_t2", rf_dest, 7);
        check("t3_val_t2", rf_wval, 32'h1234);
        check("t3_count_t2", fifo_count, 0);
        check("t3_haz_t2", hazard1, 0);
        src1 = 0;

        // 4: starvation guard
        wb_valid = 1; wb_dest = 9; wb_val = 32'h99;
        mc_valid = 1; mc_dest = 3; mc_val = 32'h33;
        tick();
        mc_valid = 0;
        for (int c = 1; c <= 8; c++) begin
            check("t4_wb_ready_early", wb_ready, 1);
            tick();
        end
        check("t4_wb_ready_c9", wb_ready, 0);
        check("t4_count_c9", fifo_count, 1);
        check("t4_dest_c9", rf_dest, 9);
        tick();
        check("t4_dest_c10", rf_dest, 3);
        check("t4_val_c10", rf_wval, 32'h33);
        check("t4_wb_ready_c10", wb_ready, 1);
        check("t4_count_c10", fifo_count, 0);
        tick();
        wb_valid = 0;
        tick();

        // 5: full FIFO, held push, pointer wrap, order preserved
        wlog.delete();
        log_en = 1;
        wb_valid = 1; wb_dest = 9; wb_val = 32'h99;
        for (int i = 0; i < 4; i++) push_hold(REG_ADDR_W'(10 + i), 32'h100 + i);
        check("t5_mc_ready_full", mc_ready, 0);
        check("t5_count_full", fifo_count, 4);
        push_hold(14, 32'h114);
        wb_valid = 0;
        for (int i = 0; i < 6; i++) push_hold(REG_ADDR_W'(15 + i), 32'h115 + i);
        repeat (10) tick();
        log_en = 0;
        check("t5_count_drained", fifo_count, 0);
        check("t5_log_size", wlog.size(), 11);
        foreach (wlog[i]) check("t5_order", wlog[i], 10 + i);

        // 6: zero register
        idle();
        mc_valid = 1; mc_dest = 0; mc_val = 32'hDEAD;
        tick();
        mc_valid = 0;
        check("t6_count_zero", fifo_count, 0);
        check("t6_mc_ready", mc_ready, 1);
        tick();
        check("t6_no_mc_write", rf_we, 0);
        wb_valid = 1; wb_dest = 0; wb_val = 32'hBEEF;
        #1 check("t6_wb_ready", wb_ready, 1);
        tick();
        wb_valid = 0;
        check("t6_no_wb_write", rf_we, 0);
        wb_valid = 1; wb_dest = 9; wb_val = 32'h99;
        push_hold(12, 32'h12);
        src1 = 0; src2 = 12;
        #1;
        check("t6_haz1_src0", hazard1, 0);
        check("t6_haz2_src12", hazard2, 1);
        idle();
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
